// File: rtl/flit_inject_stage_pkg.sv
// ----------------------------------------------------------------------------
// flit_inject_stage_pkg
// Shared constants for the deflection-router injection stage.
//   WIDTH_INTERNAL_PV : width of one internal flit word
//   POS_TIME_MSB/LSB  : location of the hop-age field inside a flit
//   WIDTH_TIME        : width of the age field, derived from POS_TIME
//   NUM_SLOTS         : number of link slots feeding the permutation network
// Helper set_time() overwrites the age field of a flit.
// ----------------------------------------------------------------------------
package flit_inject_stage_pkg;

  localparam int WIDTH_INTERNAL_PV = 24;
  localparam int POS_TIME_LSB      = 8;
  localparam int POS_TIME_MSB      = 11;
  localparam int WIDTH_TIME        = POS_TIME_MSB - POS_TIME_LSB + 1;
  localparam int NUM_SLOTS         = 4;

  localparam logic [WIDTH_TIME-1:0] TIME_MAX = '1;
  // Injected flits start at age 1 so they are the youngest valid flit.
  localparam logic [WIDTH_TIME-1:0] TIME_INJ = WIDTH_TIME'(1);

  function automatic logic [WIDTH_INTERNAL_PV-1:0] set_time(
    input logic [WIDTH_INTERNAL_PV-1:0] flit,
    input logic [WIDTH_TIME-1:0]        t
  );
    logic [WIDTH_INTERNAL_PV-1:0] r;
    r = flit;
    r[POS_TIME_MSB:POS_TIME_LSB] = t;
    return r;
  endfunction

endpackage

// File: rtl/flit_inject_stage_age_inc.sv
// ----------------------------------------------------------------------------
// age_inc
// Combinational saturating increment of the hop-age field of one flit.
//   flit_i : incoming flit
//   flit_o : same flit with age+1, held at all-ones once saturated
// ----------------------------------------------------------------------------
module age_inc
  import flit_inject_stage_pkg::*;
(
  input  logic [WIDTH_INTERNAL_PV-1:0] flit_i,
  output logic [WIDTH_INTERNAL_PV-1:0] flit_o
);

  logic [WIDTH_TIME-1:0] time_cur;
  logic [WIDTH_TIME-1:0] time_inc;

  assign time_cur = flit_i[POS_TIME_MSB:POS_TIME_LSB];
  assign time_inc = (time_cur == TIME_MAX) ? time_cur : time_cur + WIDTH_TIME'(1);
  assign flit_o   = set_time(flit_i, time_inc);

endmodule

// File: rtl/flit_inject_stage.sv
// ----------------------------------------------------------------------------
// flit_inject_stage
// Registered stage in front of the permutation network: captures four link
// flits (aging each by one hop) and merges one local flit into the
// lowest-index empty slot.
//   clk, reset         : clock, asynchronous active-high reset
//   din0..3, vin0..3   : link flits and valids
//   inj_flit/inj_valid : local injection offer
//   inj_ready          : combinational, high when any link slot is empty
//   dout0..3, vout0..3 : registered slots to the permutation network
//   starve             : registered starvation flag
// Build option: define INJ_STARVE_EN to build the starvation counter; when
// undefined, starve is tied low and STARVE_LIMIT has no effect.
// ----------------------------------------------------------------------------
module flit_inject_stage
  import flit_inject_stage_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH_INTERNAL_PV-1:0] din0,
  input  logic [WIDTH_INTERNAL_PV-1:0] din1,
  input  logic [WIDTH_INTERNAL_PV-1:0] din2,
  input  logic [WIDTH_INTERNAL_PV-1:0] din3,
  input  logic                         vin0,
  input  logic                         vin1,
  input  logic                         vin2,
  input  logic                         vin3,
  input  logic [WIDTH_INTERNAL_PV-1:0] inj_flit,
  input  logic                         inj_valid,
  output logic                         inj_ready,
  output logic [WIDTH_INTERNAL_PV-1:0] dout0,
  output logic [WIDTH_INTERNAL_PV-1:0] dout1,
  output logic [WIDTH_INTERNAL_PV-1:0] dout2,
  output logic [WIDTH_INTERNAL_PV-1:0] dout3,
  output logic                         vout0,
  output logic                         vout1,
  output logic                         vout2,
  output logic                         vout3,
  output logic                         starve
);

  logic [WIDTH_INTERNAL_PV-1:0] din_a  [NUM_SLOTS];
  logic [WIDTH_INTERNAL_PV-1:0] aged_a [NUM_SLOTS];
  logic [WIDTH_INTERNAL_PV-1:0] slot_d [NUM_SLOTS];
  logic [WIDTH_INTERNAL_PV-1:0] slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]         vin_v;
  logic [NUM_SLOTS-1:0]         valid_d;
  logic [NUM_SLOTS-1:0]         valid_q;
  logic [1:0]                   free_idx;
  logic                         inj_fire;
  logic [WIDTH_INTERNAL_PV-1:0] inj_aged;

  assign din_a[0] = din0;
  assign din_a[1] = din1;
  assign din_a[2] = din2;
  assign din_a[3] = din3;
  assign vin_v    = {vin3, vin2, vin1, vin0};

  assign inj_ready = ~&vin_v;
  assign inj_fire  = inj_valid & inj_ready;
  assign inj_aged  = set_time(inj_flit, TIME_INJ);

  // Lowest-index empty slot; descending scan so the last hit wins.
  always_comb begin
    free_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!vin_v[i]) free_idx = 2'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic take_inj;

      age_inc u_age_inc (
        .flit_i (din_a[gi]),
        .flit_o (aged_a[gi])
      );

      assign take_inj = inj_fire && (free_idx == 2'(gi));

      always_comb begin
        slot_d[gi]  = '0;
        valid_d[gi] = 1'b0;
        if (vin_v[gi]) begin
          slot_d[gi]  = aged_a[gi];
          valid_d[gi] = 1'b1;
        end else if (take_inj) begin
          slot_d[gi]  = inj_aged;
          valid_d[gi] = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_q[gi]  <= '0;
          valid_q[gi] <= 1'b0;
        end else begin
          slot_q[gi]  <= slot_d[gi];
          valid_q[gi] <= valid_d[gi];
        end
      end
    end
  endgenerate

  assign dout0 = slot_q[0];
  assign dout1 = slot_q[1];
  assign dout2 = slot_q[2];
  assign dout3 = slot_q[3];
  assign vout0 = valid_q[0];
  assign vout1 = valid_q[1];
  assign vout2 = valid_q[2];
  assign vout3 = valid_q[3];

`ifdef INJ_STARVE_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;
  logic       starve_q;

  // Counts consecutive blocked offers; any idle or successful cycle clears it.
  always_comb begin
    starve_cnt_d = '0;
    if (inj_valid && !inj_ready) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                  : starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d == STARVE_LIM);
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_flit_inject_stage.sv
module tb_flit_inject_stage;
  import flit_inject_stage_pkg::*;

  localparam int W   = WIDTH_INTERNAL_PV;
  localparam int LIM = 4;
  localparam int TMAX = (1 << WIDTH_TIME) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din0, din1, din2, din3, inj_flit;
  logic         vin0, vin1, vin2, vin3, inj_valid;
  logic         inj_ready;
  logic [W-1:0] dout0, dout1, dout2, dout3;
  logic         vout0, vout1, vout2, vout3, starve;

  int tests_run    = 0;
  int tests_failed = 0;
  int starve_cnt   = 0;   // reference starvation count
  int seq          = 0;

  always #5 clk = ~clk;

  flit_inject_stage #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .vin0(vin0), .vin1(vin1), .vin2(vin2), .vin3(vin3),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .vout0(vout0), .vout1(vout1), .vout2(vout2), .vout3(vout3),
    .starve(starve)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int time_of(input logic [W-1:0] f);
    return int'(f[POS_TIME_MSB:POS_TIME_LSB]);
  endfunction

  function automatic logic [W-1:0] with_time(input logic [W-1:0] f, input int t);
    logic [W-1:0] r;
    r = f;
    r[POS_TIME_MSB:POS_TIME_LSB] = WIDTH_TIME'(t);
    return r;
  endfunction

  // Random flit with a running sequence number in the low byte so every
  // flit offered is distinguishable.
  function automatic logic [W-1:0] rnd_flit();
    logic [W-1:0] f;
    f = W'($urandom);
    f[7:0] = 8'(seq);
    seq++;
    return f;
  endfunction

  function automatic logic [63:0] exp_starve_flag();
`ifdef INJ_STARVE_EN
    return {63'd0, starve_cnt == LIM};
`else
    return 64'd0;
`endif
  endfunction

  // Called at a falling edge: drive, check inj_ready, predict, step one edge,
  // check outputs, and return at the next falling edge.
  task automatic run_cycle(input string tag, input logic [3:0] v, input logic iv,
                           input logic [3:0][W-1:0] d, input logic [W-1:0] inj);
    int           free_q[$];
    logic [W-1:0] exp_d [4];
    logic [3:0]   exp_v;
    logic [3:0]   got_v;
    logic [W-1:0] got_d [4];
    bit           fire;
    int           nt;
    din0 = d[0]; din1 = d[1]; din2 = d[2]; din3 = d[3];
    vin0 = v[0]; vin1 = v[1]; vin2 = v[2]; vin3 = v[3];
    inj_flit = inj; inj_valid = iv;
    #1;
    for (int i = 0; i < 4; i++) if (!v[i]) free_q.push_back(i);
    check_val({tag, ".ready"}, {63'd0, inj_ready}, {63'd0, free_q.size() > 0});
    fire = iv && (free_q.size() > 0);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        nt = time_of(d[i]) + 1;
        if (nt > TMAX) nt = TMAX;
        exp_d[i] = with_time(d[i], nt);
        exp_v[i] = 1'b1;
      end else begin
        exp_d[i] = '0;
        exp_v[i] = 1'b0;
      end
    end
    if (fire) begin
      exp_d[free_q[0]] = with_time(inj, 1);
      exp_v[free_q[0]] = 1'b1;
    end
    if (iv && !fire) starve_cnt = (starve_cnt < LIM) ? starve_cnt + 1 : starve_cnt;
    else             starve_cnt = 0;
    @(posedge clk); #1;
    got_v = {vout3, vout2, vout1, vout0};
    got_d[0] = dout0; got_d[1] = dout1; got_d[2] = dout2; got_d[3] = dout3;
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s.dout%0d", tag, i), {40'd0, got_d[i]}, {40'd0, exp_d[i]});
    check_val({tag, ".vout"}, {60'd0, got_v}, {60'd0, exp_v});
    check_val({tag, ".count"}, 64'($countones(got_v)), 64'($countones(v) + (fire ? 1 : 0)));
    check_val({tag, ".starve"}, {63'd0, starve}, exp_starve_flag());
    $display("[TB] %s vin=%b inj_v=%b fire=%0d vout=%b starve=%b", tag, v, iv, fire, got_v, starve);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, ".d"}, {64'(dout0) | 64'(dout1) | 64'(dout2) | 64'(dout3)}, 64'd0);
    check_val({tag, ".v"}, {60'd0, vout3, vout2, vout1, vout0}, 64'd0);
    check_val({tag, ".starve"}, {63'd0, starve}, 64'd0);
    $display("[TB] %s reset outputs cleared", tag);
  endtask

  initial begin
    logic [3:0][W-1:0] d;
    logic [3:0]        v;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0; inj_flit = '0;
    vin0 = 0; vin1 = 0; vin2 = 0; vin3 = 0; inj_valid = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2 check_cleared("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Mid-stream reset with all slots full.
    for (int i = 0; i < 4; i++) d[i] = rnd_flit();
    run_cycle("pre", 4'b1111, 1'b0, d, rnd_flit());
    #2 reset = 1'b1;
    starve_cnt = 0;
    #1 check_cleared("mid_rst");
    @(negedge clk);
    reset = 1'b0;

    // Aging: times 3,7,0,5 -> 4,8,1,6.
    d[0] = with_time(rnd_flit(), 3); d[1] = with_time(rnd_flit(), 7);
    d[2] = with_time(rnd_flit(), 0); d[3] = with_time(rnd_flit(), 5);
    run_cycle("age", 4'b1111, 1'b0, d, rnd_flit());

    // Saturation of an all-ones age on slot 2.
    for (int i = 0; i < 4; i++) d[i] = rnd_flit();
    d[2] = with_time(d[2], TMAX);
    run_cycle("sat", 4'b0100, 1'b0, d, rnd_flit());

    // Injection placement.
    for (int i = 0; i < 4; i++) d[i] = rnd_flit();
    run_cycle("inj1010", 4'b1010, 1'b1, d, with_time(rnd_flit(), 9));
    run_cycle("inj0000", 4'b0000, 1'b1, d, rnd_flit());
    run_cycle("inj0001", 4'b0001, 1'b1, d, rnd_flit());

    // Blocked injection and starvation build-up, then release.
    run_cycle("idle", 4'b0000, 1'b0, d, rnd_flit());
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) d[i] = rnd_flit();
      run_cycle($sformatf("blk%0d", k), 4'b1111, 1'b1, d, rnd_flit());
    end
    for (int i = 0; i < 4; i++) d[i] = rnd_flit();
    run_cycle("release", 4'b1110, 1'b1, d, rnd_flit());

    // Randomized traffic, biased toward busy links so starvation also occurs.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = rnd_flit();
        v[i] = ($urandom_range(0, 9) < 7);
      end
      run_cycle($sformatf("rnd%0d", n), v, 1'($urandom_range(0, 3) != 0), d, rnd_flit());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
